// File: rtl/cop_txn_pkg.sv
// cop_txn_pkg: shared types and helpers for the COP transaction tracker.
//   - txn_entry_t : in-flight entry layout for the default configuration
//                   (XLEN=32, NREGS=16); the tracker packs the same field
//                   order for any parameterisation.
//   - RES_*       : COP result-code values.
//   - cpr_slice() : extracts one CPR from a flattened default-sized CPR file.
package cop_txn_pkg;

  localparam int ENC_W          = 32;
  localparam int XLEN_DEF       = 32;
  localparam int NREGS_DEF      = 16;
  // The aborted flag sits at the bottom of a packed entry so that the FIFO
  // head-field write port can target it with a single-bit mask.
  localparam int ENTRY_ABORT_BIT = 0;

  localparam logic [2:0] RES_OK      = 3'd0;
  localparam logic [2:0] RES_ILLEGAL = 3'd1;
  localparam logic [2:0] RES_FAULT   = 3'd2;
  localparam logic [2:0] RES_ABORT   = 3'd3;

  typedef struct packed {
    logic [ENC_W-1:0]              enc;
    logic [XLEN_DEF-1:0]           rs1;
    logic [NREGS_DEF*XLEN_DEF-1:0] cprs;
    logic                          aborted;
  } txn_entry_t;

  function automatic logic [XLEN_DEF-1:0] cpr_slice(
    input logic [NREGS_DEF*XLEN_DEF-1:0] cprs,
    input int unsigned                   idx
  );
    return cprs[idx*XLEN_DEF +: XLEN_DEF];
  endfunction

endpackage

// File: rtl/cop_txn_fifo.sv
// cop_txn_fifo: generic synchronous FIFO with a combinational head view.
// Ports:
//   g_clk, g_resetn          clock, synchronous active-low reset
//   push, push_data          enqueue at tail (ignored when full unless popping)
//   pop                      dequeue head (ignored when empty)
//   head_data                current head entry
//   full, empty, count       occupancy at the start of the cycle
//   head_wr_en/mask/data     read-modify-write of selected head bits
module cop_txn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             head_wr_en,
  input  logic [WIDTH-1:0] head_wr_mask,
  input  logic [WIDTH-1:0] head_wr_data
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A push while full is only accepted when the head leaves the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage is not reset; validity is tracked by the pointers. The push write
  // comes last so that, when full with simultaneous push/pop, the new entry
  // wins over a head-field update aimed at the slot being vacated.
  always_ff @(posedge g_clk) begin
    if (head_wr_en && !empty) begin
      mem[rd_ptr_reg] <= (mem[rd_ptr_reg] & ~head_wr_mask) | (head_wr_data & head_wr_mask);
    end
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cop_txn_tracker.sv
// cop_txn_tracker: pairs COP instruction accepts with responses and emits one
// registered record per retired instruction for the checker.
// Ports:
//   g_clk, g_resetn           clock, synchronous active-low reset
//   insn_req/ack/enc/rs1      instruction handshake and payload (accept event)
//   abort_req                 marks the oldest in-flight entry as aborted
//   insn_rsp/rsp_ack/rsp_*    response handshake and writeback (retire event)
//   cprs_snoop                live CPR file, reg i at [i*XLEN +: XLEN]
//   vtx_*                     retired record, vtx_valid is a one-cycle pulse
//   outstanding               in-flight count
//   err_overflow, err_orphan  sticky protocol error flags
module cop_txn_tracker #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int SEQ_W = 16
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     insn_req,
  input  logic                     insn_ack,
  input  logic [31:0]              insn_enc,
  input  logic [XLEN-1:0]          insn_rs1,
  input  logic                     abort_req,
  input  logic                     insn_rsp,
  input  logic                     rsp_ack,
  input  logic [2:0]               rsp_result,
  input  logic                     rsp_wen,
  input  logic [4:0]               rsp_waddr,
  input  logic [XLEN-1:0]          rsp_wdata,
  input  logic [NREGS*XLEN-1:0]    cprs_snoop,
  output logic                     vtx_valid,
  output logic [31:0]              vtx_enc,
  output logic [XLEN-1:0]          vtx_rs1,
  output logic [2:0]               vtx_result,
  output logic                     vtx_wen,
  output logic [4:0]               vtx_waddr,
  output logic [XLEN-1:0]          vtx_wdata,
  output logic                     vtx_aborted,
  output logic [SEQ_W-1:0]         vtx_seq,
  output logic [NREGS*XLEN-1:0]    vtx_cprs_pre,
  output logic [NREGS*XLEN-1:0]    vtx_cprs_post,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_overflow,
  output logic                     err_orphan
);

  import cop_txn_pkg::*;

  localparam int CPR_W   = NREGS * XLEN;
  localparam int CPR_LSB = ENTRY_ABORT_BIT + 1;
  localparam int RS1_LSB = CPR_LSB + CPR_W;
  localparam int ENC_LSB = RS1_LSB + XLEN;
  localparam int ENTRY_W = ENC_LSB + ENC_W;

  logic               accept_ev;
  logic               resp_ev;
  logic               pop_ev;
  logic               orphan_ev;
  logic               overflow_ev;
  logic               abort_hit;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [SEQ_W-1:0]   seq_cnt_reg;

  assign accept_ev   = insn_req && insn_ack;
  assign resp_ev     = insn_rsp && rsp_ack;
  // All decisions use the occupancy held at the start of the cycle.
  assign pop_ev      = resp_ev && !fifo_empty;
  assign orphan_ev   = resp_ev && fifo_empty;
  assign overflow_ev = accept_ev && fifo_full && !pop_ev;
  assign abort_hit   = abort_req && !fifo_empty;

  assign push_entry = {insn_enc, insn_rs1, cprs_snoop, 1'b0};

  cop_txn_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .push         (accept_ev),
    .push_data    (push_entry),
    .pop          (pop_ev),
    .head_data    (head_entry),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (outstanding),
    .head_wr_en   (abort_hit),
    .head_wr_mask (ENTRY_W'(1) << ENTRY_ABORT_BIT),
    .head_wr_data (ENTRY_W'(1) << ENTRY_ABORT_BIT)
  );

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      vtx_valid     <= 1'b0;
      vtx_enc       <= '0;
      vtx_rs1       <= '0;
      vtx_result    <= '0;
      vtx_wen       <= 1'b0;
      vtx_waddr     <= '0;
      vtx_wdata     <= '0;
      vtx_aborted   <= 1'b0;
      vtx_seq       <= '0;
      vtx_cprs_pre  <= '0;
      vtx_cprs_post <= '0;
      seq_cnt_reg   <= '0;
      err_overflow  <= 1'b0;
      err_orphan    <= 1'b0;
    end else begin
      vtx_valid <= pop_ev;
      if (pop_ev) begin
        vtx_enc       <= head_entry[ENC_LSB +: ENC_W];
        vtx_rs1       <= head_entry[RS1_LSB +: XLEN];
        vtx_cprs_pre  <= head_entry[CPR_LSB +: CPR_W];
        // An abort arriving in the retire cycle has not reached the stored
        // entry yet, so fold it in here.
        vtx_aborted   <= head_entry[ENTRY_ABORT_BIT] | abort_hit;
        vtx_result    <= rsp_result;
        vtx_wen       <= rsp_wen;
        vtx_waddr     <= rsp_waddr;
        vtx_wdata     <= rsp_wdata;
        vtx_cprs_post <= cprs_snoop;
        vtx_seq       <= seq_cnt_reg;
        seq_cnt_reg   <= seq_cnt_reg + SEQ_W'(1);
      end
      if (overflow_ev) err_overflow <= 1'b1;
      if (orphan_ev)   err_orphan   <= 1'b1;
    end
  end

endmodule
